// File: rtl/column_path_loader.sv
// Sequences clear, serial path load and run-length accumulate strobes for one node column.
// Latency: CLEAR one cycle after accept, N_NODES shift cycles, run_len load cycles, then a done pulse.
// Backpressure: cfg_ready_o is low whenever busy; an abort or reset returns the loader to IDLE.
module column_path_loader #(
    parameter int N_NODES   = 8,
    parameter int LEN_WIDTH = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 cfg_valid_i,
    output logic                 cfg_ready_o,
    input  logic [N_NODES-1:0]   cfg_sel_i,
    input  logic [N_NODES-1:0]   cfg_en_i,
    input  logic [LEN_WIDTH-1:0] cfg_run_len_i,
    input  logic                 abort_i,
    input  logic                 c_node_i,
    output logic                 sel_mux_path_o,
    output logic                 en_adder_path_o,
    output logic                 path_node_ld_o,
    output logic                 path_node_rst_o,
    output logic                 node_rst_o,
    output logic                 node_ld_o,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 ovf_o
);
    localparam int CW = $clog2(N_NODES);

    typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_SHIFT, S_RUN, S_DONE} state_t;

    state_t               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [N_NODES-1:0]   sel_q, sel_d, en_q, en_d;
    logic [LEN_WIDTH-1:0] run_q, run_d;
    logic                 ovf_d, abort_clr;
    logic                 ready_d, done_d, clr_d, path_ld_d, node_ld_d, sel_bit_d, en_bit_d;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        sel_d     = sel_q;
        en_d      = en_q;
        run_d     = run_q;
        ovf_d     = ovf_o;
        abort_clr = 1'b0;
        sel_bit_d = 1'b0;
        en_bit_d  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (cfg_valid_i && cfg_ready_o) begin
                    sel_d   = cfg_sel_i;
                    en_d    = cfg_en_i;
                    run_d   = cfg_run_len_i;
                    ovf_d   = 1'b0;
                    state_d = S_CLEAR;
                end
            end
            S_CLEAR: begin
                cnt_d   = '0;
                state_d = S_SHIFT;
            end
            S_SHIFT: begin
                if (cnt_q == CW'(N_NODES - 1))
                    state_d = (run_q != '0) ? S_RUN : S_DONE;
                else
                    cnt_d = cnt_q + 1'b1;
            end
            S_RUN: begin
                if (c_node_i)
                    ovf_d = 1'b1;
                run_d = run_q - 1'b1;
                if (run_q == LEN_WIDTH'(1))
                    state_d = S_DONE;
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        if (abort_i && (state_q == S_CLEAR || state_q == S_SHIFT || state_q == S_RUN)) begin
            state_d   = S_IDLE;
            abort_clr = 1'b1;
        end

        // Outputs are decoded from the next state so they line up with the state register.
        ready_d   = (state_d == S_IDLE);
        done_d    = (state_d == S_DONE);
        node_ld_d = (state_d == S_RUN);
        path_ld_d = (state_d == S_SHIFT);
        clr_d     = (state_d == S_CLEAR) || abort_clr;

        // Top node receives the highest bit first so node k ends up with bit k.
        if (state_d == S_SHIFT) begin
            sel_bit_d = sel_q[N_NODES-1];
            en_bit_d  = en_q[N_NODES-1];
            sel_d     = {sel_q[N_NODES-2:0], 1'b0};
            en_d      = {en_q[N_NODES-2:0], 1'b0};
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q         <= S_IDLE;
            cnt_q           <= '0;
            sel_q           <= '0;
            en_q            <= '0;
            run_q           <= '0;
            cfg_ready_o     <= 1'b1;
            busy_o          <= 1'b0;
            done_o          <= 1'b0;
            ovf_o           <= 1'b0;
            sel_mux_path_o  <= 1'b0;
            en_adder_path_o <= 1'b0;
            path_node_ld_o  <= 1'b0;
            path_node_rst_o <= 1'b0;
            node_rst_o      <= 1'b0;
            node_ld_o       <= 1'b0;
        end else begin
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            sel_q           <= sel_d;
            en_q            <= en_d;
            run_q           <= run_d;
            cfg_ready_o     <= ready_d;
            busy_o          <= ~ready_d;
            done_o          <= done_d;
            ovf_o           <= ovf_d;
            sel_mux_path_o  <= sel_bit_d;
            en_adder_path_o <= en_bit_d;
            path_node_ld_o  <= path_ld_d;
            path_node_rst_o <= clr_d;
            node_rst_o      <= clr_d;
            node_ld_o       <= node_ld_d;
        end
    end
endmodule

// File: tb/tb_column_path_loader.sv
// Scoreboard bench for column_path_loader with a four-node column.
module tb_column_path_loader;
    localparam int N  = 4;
    localparam int LW = 8;

    typedef struct {
        int lat;
        int ld;
        bit ovf;
    } txn_t;

    logic          clk_i = 1'b0;
    logic          rst_i = 1'b1;
    logic          cfg_valid_i = 1'b0;
    logic          cfg_ready_o;
    logic [N-1:0]  cfg_sel_i = '0;
    logic [N-1:0]  cfg_en_i = '0;
    logic [LW-1:0] cfg_run_len_i = '0;
    logic          abort_i = 1'b0;
    logic          c_node_i = 1'b0;
    logic          sel_mux_path_o, en_adder_path_o, path_node_ld_o, path_node_rst_o;
    logic          node_rst_o, node_ld_o, busy_o, done_o, ovf_o;

    int   vec_cnt = 0;
    int   err_cnt = 0;
    int   cyc = 0;
    int   acc_cyc = 0;
    int   ld_cnt = 0;
    logic [1:0] exp_ser[$];
    txn_t       exp_txn[$];

    column_path_loader #(.N_NODES(N), .LEN_WIDTH(LW)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .cfg_valid_i(cfg_valid_i), .cfg_ready_o(cfg_ready_o),
        .cfg_sel_i(cfg_sel_i), .cfg_en_i(cfg_en_i), .cfg_run_len_i(cfg_run_len_i),
        .abort_i(abort_i), .c_node_i(c_node_i),
        .sel_mux_path_o(sel_mux_path_o), .en_adder_path_o(en_adder_path_o),
        .path_node_ld_o(path_node_ld_o), .path_node_rst_o(path_node_rst_o),
        .node_rst_o(node_rst_o), .node_ld_o(node_ld_o),
        .busy_o(busy_o), .done_o(done_o), .ovf_o(ovf_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Monitor: pops serial bits during shift, and whole-transaction results at done.
    initial begin
        txn_t t;
        logic [1:0] s;
        forever begin
            @(negedge clk_i);
            cyc++;
            if (path_node_ld_o) begin
                if (exp_ser.size() == 0) check("spurious_shift", {31'd0, path_node_ld_o}, 0);
                else begin
                    s = exp_ser.pop_front();
                    check("serial", {30'd0, sel_mux_path_o, en_adder_path_o}, {30'd0, s});
                end
            end
            if (node_ld_o) ld_cnt++;
            if (done_o) begin
                if (exp_txn.size() == 0) check("spurious_done", {31'd0, done_o}, 0);
                else begin
                    t = exp_txn.pop_front();
                    check("done_latency", cyc - acc_cyc, t.lat);
                    check("node_ld_cycles", ld_cnt, t.ld);
                    check("ovf_at_done", {31'd0, ovf_o}, {31'd0, t.ovf});
                end
            end
            if (cfg_valid_i && cfg_ready_o && !rst_i) begin
                acc_cyc = cyc;
                ld_cnt  = 0;
            end
        end
    end

    task automatic push_ser(input logic [N-1:0] s, input logic [N-1:0] e, input int nbits);
        for (int i = 0; i < nbits; i++) exp_ser.push_back({s[N-1-i], e[N-1-i]});
    endtask

    task automatic wait_ready();
        int g = 0;
        do begin @(negedge clk_i); g++; end while (!cfg_ready_o && g < 100);
        check("accept_ready", {31'd0, cfg_ready_o}, 1);
    endtask

    // Offers a request, returns at the negedge of the CLEAR cycle.
    task automatic offer(input logic [N-1:0] s, input logic [N-1:0] e, input logic [LW-1:0] l,
                         input bit ab, input int nbits);
        @(posedge clk_i); #1;
        cfg_valid_i = 1'b1; cfg_sel_i = s; cfg_en_i = e; cfg_run_len_i = l; abort_i = ab;
        wait_ready();
        push_ser(s, e, nbits);
        @(posedge clk_i); #1;
        cfg_valid_i = 1'b0; abort_i = 1'b0;
        cfg_sel_i = N'($urandom); cfg_en_i = N'($urandom); cfg_run_len_i = LW'($urandom);
        @(negedge clk_i);
        check("clear_path_rst", {31'd0, path_node_rst_o}, 1);
        check("clear_node_rst", {31'd0, node_rst_o}, 1);
        check("clear_ovf", {31'd0, ovf_o}, 0);
        check("clear_busy", {31'd0, busy_o}, 1);
    endtask

    task automatic wait_done(input bit ab_in_done);
        int g = 0;
        do begin @(negedge clk_i); g++; end while (!done_o && g < 200);
        check("done_seen", {31'd0, done_o}, 1);
        if (ab_in_done) begin
            abort_i = 1'b1;
            @(posedge clk_i); #1;
            abort_i = 1'b0;
        end
        @(negedge clk_i);
        check("idle_ready", {31'd0, cfg_ready_o}, 1);
        check("idle_busy", {31'd0, busy_o}, 0);
        check("idle_done", {31'd0, done_o}, 0);
        check("idle_no_clear", {31'd0, path_node_rst_o}, 0);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_ready"}, {31'd0, cfg_ready_o}, 1);
        check({tag, "_busy"}, {31'd0, busy_o}, 0);
        check({tag, "_done"}, {31'd0, done_o}, 0);
        check({tag, "_ovf"}, {31'd0, ovf_o}, 0);
        check({tag, "_strobes"}, {26'd0, path_node_ld_o, path_node_rst_o, node_rst_o, node_ld_o,
                                  sel_mux_path_o, en_adder_path_o}, 0);
    endtask

    initial begin
        #100_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk_i);
        #1 rst_i = 1'b0;
        @(negedge clk_i);
        check_reset_vals("reset");

        // Basic load: bits shift MSB first, three load cycles.
        offer(4'b0101, 4'b1010, 8'd3, 1'b0, N);
        exp_txn.push_back('{lat: 2 + N + 3, ld: 3, ovf: 1'b0});
        wait_done(1'b0);

        // Zero run length; abort with valid in IDLE is accepted, abort in DONE is ignored.
        offer(4'b1100, 4'b0011, 8'd0, 1'b1, N);
        exp_txn.push_back('{lat: 2 + N, ld: 0, ovf: 1'b0});
        wait_done(1'b1);

        // Overflow: carry in RUN cycle 2, sticky through DONE and IDLE.
        offer(4'b1111, 4'b0110, 8'd4, 1'b0, N);
        exp_txn.push_back('{lat: 2 + N + 4, ld: 4, ovf: 1'b1});
        repeat (N + 2) @(posedge clk_i);
        #1 c_node_i = 1'b1;
        @(negedge clk_i);
        check("ovf_before_carry", {31'd0, ovf_o}, 0);
        @(posedge clk_i); #1 c_node_i = 1'b0;
        @(negedge clk_i);
        check("ovf_after_carry", {31'd0, ovf_o}, 1);
        wait_done(1'b0);
        check("ovf_sticky_idle", {31'd0, ovf_o}, 1);

        // Abort in SHIFT cycle 1 (also confirms the CLEAR of this request drops ovf).
        offer(4'b1001, 4'b0111, 8'd2, 1'b0, 2);
        @(posedge clk_i); #1;
        @(posedge clk_i); #1 abort_i = 1'b1;
        @(posedge clk_i); #1 abort_i = 1'b0;
        @(negedge clk_i);
        check("abort_ready", {31'd0, cfg_ready_o}, 1);
        check("abort_busy", {31'd0, busy_o}, 0);
        check("abort_path_rst", {31'd0, path_node_rst_o}, 1);
        check("abort_node_rst", {31'd0, node_rst_o}, 1);
        check("abort_no_shift", {31'd0, path_node_ld_o}, 0);
        @(negedge clk_i);
        check("abort_rst_pulse_end", {30'd0, path_node_rst_o, node_rst_o}, 0);
        repeat (10) @(negedge clk_i);

        // Back-to-back with valid held high; inputs changed while busy must not leak in.
        @(posedge clk_i); #1;
        cfg_valid_i = 1'b1; cfg_sel_i = 4'b0011; cfg_en_i = 4'b0101; cfg_run_len_i = 8'd2;
        wait_ready();
        push_ser(4'b0011, 4'b0101, N);
        exp_txn.push_back('{lat: 2 + N + 2, ld: 2, ovf: 1'b0});
        @(posedge clk_i); #1;
        cfg_sel_i = 4'b1110; cfg_en_i = 4'b1000; cfg_run_len_i = 8'd1;
        begin
            int g = 0;
            do begin @(negedge clk_i); g++; end while (!done_o && g < 200);
            check("b2b_first_done", {31'd0, done_o}, 1);
        end
        @(negedge clk_i);
        check("b2b_ready_after_done", {31'd0, cfg_ready_o}, 1);
        push_ser(4'b1110, 4'b1000, N);
        exp_txn.push_back('{lat: 2 + N + 1, ld: 1, ovf: 1'b0});
        @(posedge clk_i); #1;
        cfg_valid_i = 1'b0;
        cfg_sel_i = N'($urandom); cfg_en_i = N'($urandom); cfg_run_len_i = LW'($urandom);
        wait_done(1'b0);

        // Reset in RUN after an overflow: everything back to reset values, no done.
        offer(4'b0110, 4'b1011, 8'd5, 1'b0, N);
        repeat (5) @(posedge clk_i);
        #1 c_node_i = 1'b1;
        @(posedge clk_i); #1 c_node_i = 1'b0; rst_i = 1'b1;
        @(negedge clk_i);
        check("pre_reset_run", {30'd0, node_ld_o, ovf_o}, 32'd3);
        @(posedge clk_i); #1 rst_i = 1'b0;
        @(negedge clk_i);
        check_reset_vals("run_reset");
        repeat (12) @(negedge clk_i);

        // Fresh request after reset uses only its own configuration.
        offer(4'b1000, 4'b0001, 8'd1, 1'b0, N);
        exp_txn.push_back('{lat: 2 + N + 1, ld: 1, ovf: 1'b0});
        wait_done(1'b0);

        repeat (4) @(negedge clk_i);
        check("serial_queue_empty", exp_ser.size(), 0);
        check("txn_queue_empty", exp_txn.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end
endmodule
